// File: rtl/mc_pkg.sv
// Shared types and constants for the line-granular memory controller.
// The optional read watchdog is enabled by defining MC_TIMEOUT_EN.
package mc_pkg;

    localparam int LINE_W           = 512;
    localparam int LINE_OFFSET_BITS = 6;

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_BEATS,
        RESP,
        WR_REQ,
        WR_BEATS,
        WR_ACK,
        COOLDOWN
    } mc_state_e;

    typedef enum logic [1:0] {
        INSTR,
        DATA,
        EVICT
    } req_id_e;

    function automatic logic [31:0] line_align(input logic [31:0] addr);
        return {addr[31:LINE_OFFSET_BITS], {LINE_OFFSET_BITS{1'b0}}};
    endfunction

endpackage

// File: rtl/mc_line_buffer.sv
// One cache line of storage: whole-line load, beat-indexed write for read
// assembly and beat-indexed read mux for evict disassembly.
module mc_line_buffer #(
    parameter int BEATS  = 8,
    parameter int BEAT_W = 64
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        load_en,
    input  logic [BEATS*BEAT_W-1:0]     load_data,
    input  logic                        wr_en,
    input  logic [$clog2(BEATS)-1:0]    wr_idx,
    input  logic [BEAT_W-1:0]           wr_data,
    input  logic [$clog2(BEATS)-1:0]    rd_idx,
    output logic [BEAT_W-1:0]           rd_data,
    output logic [BEATS*BEAT_W-1:0]     line
);

    logic [BEATS*BEAT_W-1:0] line_q, line_d;

    always_comb begin
        line_d = line_q;
        if (load_en) begin
            line_d = load_data;
        end else if (wr_en) begin
            line_d[int'(wr_idx)*BEAT_W +: BEAT_W] = wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            line_q <= '0;
        end else begin
            line_q <= line_d;
        end
    end

    assign rd_data = line_q[int'(rd_idx)*BEAT_W +: BEAT_W];
    assign line    = line_q;

endmodule

// File: rtl/mem_ctrl.sv
// Memory controller: arbitrates evict / data-miss / fetch-miss level requests and
// moves whole lines to/from host memory in beats. Define MC_TIMEOUT_EN for the read watchdog.
module mem_ctrl
    import mc_pkg::*;
#(
    parameter int BEATS          = 8,
    parameter int BEAT_W         = 64,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cacheMissFetch,
    input  logic [31:0]       instrAddr,
    input  logic              cacheMissMemory,
    input  logic [31:0]       mcDataAddr,
    input  logic              dCacheEvict,
    input  logic [31:0]       evictAddr,
    input  logic [LINE_W-1:0] dCacheOut,
    output logic              mcInstrValid,
    output logic [LINE_W-1:0] mcInstrIn,
    output logic              mcDataValid,
    output logic [LINE_W-1:0] mcDataIn,
    output logic              evictDone,
    output logic              hostReqValid,
    input  logic              hostReqReady,
    output logic              hostReqWrite,
    output logic [31:0]       hostReqAddr,
    output logic              hostWrValid,
    input  logic              hostWrReady,
    output logic [BEAT_W-1:0] hostWrData,
    input  logic              hostWrAck,
    input  logic              hostRdValid,
    input  logic [BEAT_W-1:0] hostRdData,
    output logic              mcTimeout
);

    localparam int IDX_W = $clog2(BEATS);
    localparam logic [IDX_W-1:0] LAST_BEAT = IDX_W'(BEATS - 1);
    localparam bit CFG_OK = (BEATS * BEAT_W == LINE_W) && (TIMEOUT_CYCLES > 1);

    if (!CFG_OK) begin : g_bad_config
        $error("mem_ctrl: BEATS*BEAT_W must equal LINE_W and TIMEOUT_CYCLES must exceed 1");
    end

    mc_state_e         state_q, state_d;
    req_id_e           id_q, id_d;
    logic [31:0]       addr_q, addr_d;
    logic [IDX_W-1:0]  beat_q, beat_d;
    logic [LINE_W-1:0] instr_line_q, instr_line_d;
    logic [LINE_W-1:0] data_line_q, data_line_d;

    logic              buf_load, buf_wr, timeout_hit;
    logic [LINE_W-1:0] buf_load_data, buf_line;
    logic [BEAT_W-1:0] buf_rd_data;

    mc_line_buffer #(.BEATS(BEATS), .BEAT_W(BEAT_W)) u_line_buffer (
        .clk       (clk),
        .rst       (rst),
        .load_en   (buf_load),
        .load_data (buf_load_data),
        .wr_en     (buf_wr),
        .wr_idx    (beat_q),
        .wr_data   (hostRdData),
        .rd_idx    (beat_q),
        .rd_data   (buf_rd_data),
        .line      (buf_line)
    );

    // Misses clear the buffer on acceptance so beats that never arrive read back as zero.
    always_comb begin
        state_d       = state_q;
        id_d          = id_q;
        addr_d        = addr_q;
        beat_d        = beat_q;
        buf_load      = 1'b0;
        buf_load_data = '0;
        buf_wr        = 1'b0;
        case (state_q)
            IDLE: begin
                if (dCacheEvict) begin
                    id_d          = EVICT;
                    addr_d        = line_align(evictAddr);
                    buf_load      = 1'b1;
                    buf_load_data = dCacheOut;
                    state_d       = WR_REQ;
                end else if (cacheMissMemory) begin
                    id_d     = DATA;
                    addr_d   = line_align(mcDataAddr);
                    buf_load = 1'b1;
                    state_d  = RD_REQ;
                end else if (cacheMissFetch) begin
                    id_d     = INSTR;
                    addr_d   = line_align(instrAddr);
                    buf_load = 1'b1;
                    state_d  = RD_REQ;
                end
            end
            RD_REQ: begin
                if (hostReqReady) begin
                    beat_d  = '0;
                    state_d = RD_BEATS;
                end
            end
            RD_BEATS: begin
                if (hostRdValid) begin
                    buf_wr = 1'b1;
                    if (beat_q == LAST_BEAT) begin
                        state_d = RESP;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end else if (timeout_hit) begin
                    state_d = RESP;
                end
            end
            RESP:     state_d = COOLDOWN;
            WR_REQ: begin
                if (hostReqReady) begin
                    beat_d  = '0;
                    state_d = WR_BEATS;
                end
            end
            WR_BEATS: begin
                if (hostWrReady) begin
                    if (beat_q == LAST_BEAT) begin
                        state_d = WR_ACK;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            WR_ACK: begin
                if (hostWrAck) begin
                    state_d = COOLDOWN;
                end
            end
            COOLDOWN: state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            id_q    <= INSTR;
            addr_q  <= '0;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            addr_q  <= addr_d;
            beat_q  <= beat_d;
        end
    end

    assign mcInstrValid = (state_q == RESP) && (id_q == INSTR);
    assign mcDataValid  = (state_q == RESP) && (id_q == DATA);
    assign evictDone    = (state_q == COOLDOWN) && (id_q == EVICT);
    assign hostReqValid = (state_q == RD_REQ) || (state_q == WR_REQ);
    assign hostReqWrite = (state_q == WR_REQ);
    assign hostReqAddr  = addr_q;
    assign hostWrValid  = (state_q == WR_BEATS);
    assign hostWrData   = hostWrValid ? buf_rd_data : '0;

    // The refill line is visible during the pulse itself, then held until that port's next refill.
    always_comb begin
        instr_line_d = instr_line_q;
        data_line_d  = data_line_q;
        if (mcInstrValid) begin
            instr_line_d = buf_line;
        end
        if (mcDataValid) begin
            data_line_d = buf_line;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            instr_line_q <= '0;
            data_line_q  <= '0;
        end else begin
            instr_line_q <= instr_line_d;
            data_line_q  <= data_line_d;
        end
    end

    assign mcInstrIn = mcInstrValid ? buf_line : instr_line_q;
    assign mcDataIn  = mcDataValid  ? buf_line : data_line_q;

`ifdef MC_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES);

    logic [TO_W-1:0] idle_cnt_q, idle_cnt_d;
    logic            timeout_q, timeout_d;

    // Counts consecutive beat-less cycles in RD_BEATS; any beat or leaving the state restarts it.
    always_comb begin
        idle_cnt_d  = '0;
        timeout_d   = timeout_q;
        timeout_hit = 1'b0;
        if ((state_q == RD_BEATS) && !hostRdValid) begin
            if (idle_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
                timeout_hit = 1'b1;
                timeout_d   = 1'b1;
            end else begin
                idle_cnt_d = idle_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idle_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            idle_cnt_q <= idle_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    assign mcTimeout = timeout_q;
`else
    assign timeout_hit = 1'b0;
    assign mcTimeout   = 1'b0;
`endif

endmodule

// File: doc/mem_ctrl.md
# mem_ctrl

Line-granular memory controller on the response side of the CPU's cache-miss/evict interface. Accepts instruction-fetch misses, data misses and dCache evictions as level requests, arbitrates them, moves each 512-bit line to/from host memory as 8 × 64-bit beats, and returns refill data or an evict acknowledge. Sits in `proc` beside `cpu` and `accelerator`, driving `mcInstrValid`/`mcInstrIn`, `mcDataValid`/`mcDataIn` and `evictDone`.

## Interface
- BEATS, 8, beats per cache line
- BEAT_W, 64, host data width; BEATS*BEAT_W must equal 512
- TIMEOUT_CYCLES, 1024, read-beat watchdog limit (only with MC_TIMEOUT_EN)
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  reset, asynchronous, active-low
- cacheMissFetch / instrAddr  in  1 / 32  iCache miss level and fetch address
- cacheMissMemory / mcDataAddr  in  1 / 32  dCache miss level and data address
- dCacheEvict / evictAddr / dCacheOut  in  1 / 32 / 512  evict level, victim address, victim line
- mcInstrValid / mcInstrIn  out  1 / 512  one-cycle refill pulse and line for iCache
- mcDataValid / mcDataIn  out  1 / 512  one-cycle refill pulse and line for dCache
- evictDone  out  1  one-cycle pulse: victim committed to host
- hostReqValid / hostReqReady  out / in  1 / 1  host request handshake
- hostReqWrite / hostReqAddr  out  1 / 32  1 = write line; address line-aligned (bits [5:0] = 0)
- hostWrValid / hostWrReady / hostWrData  out / in / out  1 / 1 / 64  write-beat handshake
- hostWrAck  in  1  host write commit, one pulse per write request
- hostRdValid / hostRdData  in  1 / 64  read beats, no backpressure
- mcTimeout  out  1  sticky watchdog flag (MC_TIMEOUT_EN only)

## Operation
- States: IDLE, RD_REQ, RD_BEATS, RESP, WR_REQ, WR_BEATS, WR_ACK, COOLDOWN.
- IDLE priority: dCacheEvict > cacheMissMemory > cacheMissFetch. Winner's address latched with [5:0] cleared; requester ID latched; evict line copied to line buffer.
- Miss: IDLE → RD_REQ (hostReqValid=1, hostReqWrite=0) until hostReqReady → RD_BEATS; beat k fills bits [64k+63:64k], beat 0 first; after beat BEATS-1 → RESP.
- RESP: exactly one of mcInstrValid/mcDataValid high one cycle per latched ID; mcInstrIn/mcDataIn hold the line from RESP until next refill of that port.
- Evict: IDLE → WR_REQ (hostReqWrite=1) → WR_BEATS, beat k = dCacheOut bits [64k+63:64k], beat advances only when hostWrValid&hostWrReady → WR_ACK; on hostWrAck, evictDone pulses one cycle → COOLDOWN.
- RESP → COOLDOWN. COOLDOWN lasts one cycle, ignores all requests (requester drops its level on the edge it sees the pulse) → IDLE.
- Requests arriving while busy wait; no queueing beyond the held level. Evict+data miss same cycle: write-back completes before refill.
- hostRdValid outside RD_BEATS and hostWrAck outside WR_ACK are ignored.
- Beat counter is $clog2(BEATS) bits, cleared on entering RD_BEATS/WR_BEATS; no wrap inside a line.

## Timing
- Reset (rst=0, async): state IDLE, counter 0, all valid/pulse outputs 0, hostReqValid/hostWrValid 0, mcInstrIn/mcDataIn/hostWrData/hostReqAddr 0, mcTimeout 0. Reset mid-transfer discards partial line; no response issued.
- Read latency, ideal host (ready immediate, beats back-to-back from cycle after accept): request seen in IDLE at cycle 0, hostReqValid cycle 1, beats cycles 2–9, refill pulse cycle 10, IDLE at cycle 12.
- Write, ideal host: hostReqValid cycle 1, beats cycles 2–9, WR_ACK from cycle 10, evictDone the cycle after hostWrAck.
- hostReqValid/hostReqAddr/hostReqWrite stable until accepted; hostWrValid/hostWrData stable until accepted.

## Configuration
- MC_TIMEOUT_EN defined: counter resets on each read beat; if RD_BEATS sees no beat for TIMEOUT_CYCLES cycles, mcTimeout sets (sticky until reset), FSM → RESP delivering the line with missing beats zero.
- Undefined: no counter, mcTimeout tied 0, RD_BEATS waits indefinitely.

## Structure
- mc_pkg: state enum, requester-ID enum (INSTR, DATA, EVICT), LINE_W=512, LINE_OFFSET_BITS=6.
- Sub-module mc_line_buffer: 512-bit register with beat-indexed write (read assembly) and beat-indexed read mux (evict disassembly).

## Test plan
- Fetch miss at instrAddr=0x0000_1234, ideal host beats 0x0..0x7 → hostReqAddr=0x0000_1200, mcInstrValid at cycle 10, mcInstrIn[63:0]=0, [511:448]=7.
- Evict (evictAddr=0x40) and data miss (0x80) same cycle → write at 0x40 first, evictDone, then read at 0x80, mcDataValid; never both pulses same cycle.
- Host stalls hostWrReady low 3 cycles on beat 4 → hostWrData holds beat 4 value, 8 beats total, one evictDone.
- Fetch and data miss held together → data served first, fetch refill follows after COOLDOWN.
- rst low during beat 5 of read → outputs all 0 immediately, no mcDataValid; held miss re-issued from IDLE after release.
- MC_TIMEOUT_EN, TIMEOUT_CYCLES=16, host sends 3 beats then stops → mcTimeout=1 after 16 idle cycles, mcDataValid with beats 3–7 zero.
